button_move_sequencer: RTL and testbench

Converts the four debounced switch levels into one-cycle movement strobes and a one-cycle game-start strobe for the Frogger game logic. Sits directly downstream of `multi_button_debouncer` and upstream of `frogger_game`, replacing raw level inputs with edge-qualified, prioritised, optionally auto-repeating commands. A four-button chord held for a programmable time produces the start strobe instead of moves.

---
 rtl/button_move_sequencer.sv | 173 +++++++++++++++++
 tb/tb_button_move_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/button_move_sequencer.sv
// button_move_sequencer: debounced levels -> prioritised one-cycle move
// strobes, optional auto-repeat, and a four-button chord start strobe.
// Ports: i_Clk, i_Rst (sync, active-high), i_Buttons[3:0] (up,down,left,right),
//        o_Move[3:0] one-hot strobe, o_Game_Start strobe, o_Chord level.
// Option: define BUTTON_AUTO_REPEAT_EN to enable held-button auto-repeat.
module button_move_sequencer #(
  parameter int REPEAT_DELAY  = 12_500_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int START_HOLD    = 25_000_000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [3:0] i_Buttons,
  output logic [3:0] o_Move,
  output logic       o_Game_Start,
  output logic       o_Chord
);

  localparam int MAX_DP  = (REPEAT_DELAY > REPEAT_PERIOD) ?
                           REPEAT_DELAY : REPEAT_PERIOD;
  localparam int MAX_ALL = (MAX_DP > START_HOLD) ? MAX_DP : START_HOLD;
  localparam int CW      = $clog2(MAX_ALL) + 1;

  localparam logic [CW-1:0] HOLD_END = CW'(START_HOLD - 1);
  localparam logic [CW-1:0] HOLD_PRE = CW'(START_HOLD - 2);

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [CW-1:0] DLY_END = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_END = CW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    HELD_DELAY,
    HELD_REPEAT,
    CHORD
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    HELD,
    CHORD
  } state_t;
`endif

  state_t        state, state_n;
  logic [CW-1:0] count, count_n;
  logic [3:0]    prev;
  logic [1:0]    dir, dir_n, low;
  logic [3:0]    move_n;
  logic          start_n;
  logic [3:0]    rise;
  logic          all_on;
  logic          dir_on;

  assign rise    = i_Buttons & ~prev;
  assign all_on  = &i_Buttons;
  assign dir_on  = i_Buttons[dir];
  assign o_Chord = (state == CHORD);

  // Lowest-index rising button wins a simultaneous press.
  always_comb begin
    low = 2'd0;
    priority case (1'b1)
      rise[0]: low = 2'd0;
      rise[1]: low = 2'd1;
      rise[2]: low = 2'd2;
      rise[3]: low = 2'd3;
      default: low = 2'd0;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state        <= IDLE;
      count        <= '0;
      prev         <= 4'hF;
      dir          <= 2'd0;
      o_Move       <= 4'd0;
      o_Game_Start <= 1'b0;
    end else begin
      state        <= state_n;
      count        <= count_n;
      prev         <= i_Buttons;
      dir          <= dir_n;
      o_Move       <= move_n;
      o_Game_Start <= start_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    dir_n   = dir;
    move_n  = 4'd0;
    start_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (all_on) begin
          state_n = CHORD;
          count_n = '0;
        end else if (|rise) begin
          dir_n   = low;
          move_n  = 4'b0001 << low;
          count_n = '0;
`ifdef BUTTON_AUTO_REPEAT_EN
          state_n = HELD_DELAY;
`else
          state_n = HELD;
`endif
        end
      end
`ifdef BUTTON_AUTO_REPEAT_EN
      // Release outranks a repeat falling due in the same cycle.
      HELD_DELAY: begin
        if (!dir_on) begin
          state_n = IDLE;
          count_n = '0;
        end else if (all_on) begin
          state_n = CHORD;
          count_n = '0;
        end else if (count == DLY_END) begin
          move_n  = 4'b0001 << dir;
          state_n = HELD_REPEAT;
          count_n = '0;
        end else begin
          count_n = count + 1'b1;
        end
      end
      HELD_REPEAT: begin
        if (!dir_on) begin
          state_n = IDLE;
          count_n = '0;
        end else if (all_on) begin
          state_n = CHORD;
          count_n = '0;
        end else if (count == PER_END) begin
          move_n  = 4'b0001 << dir;
          count_n = '0;
        end else begin
          count_n = count + 1'b1;
        end
      end
`else
      HELD: begin
        if (!dir_on) begin
          state_n = IDLE;
          count_n = '0;
        end else if (all_on) begin
          state_n = CHORD;
          count_n = '0;
        end
      end
`endif
      // Start fires as the count steps onto its saturation value.
      CHORD: begin
        if (!all_on) begin
          state_n = IDLE;
          count_n = '0;
        end else if (count == HOLD_PRE) begin
          start_n = 1'b1;
          count_n = HOLD_END;
        end else if (count != HOLD_END) begin
          count_n = count + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_move_sequencer.sv
// tb_button_move_sequencer: directed checks of strobes, repeat,
// chord start and reset for button_move_sequencer (D=8, P=4, S=16).
module tb_button_move_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'd0;
  logic [3:0] move;
  logic       start;
  logic       chord;

  int checks = 0;
  int fails  = 0;

  logic [63:0] pmask;
  logic [63:0] smask;
  logic [3:0]  mv_or;
  int          chord_cnt;
  int          start_cnt;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [31:0] EXP_RIGHT = 32'h1111_1101;
  localparam logic [31:0] EXP_UPL   = 32'h0000_1101;
`else
  localparam logic [31:0] EXP_RIGHT = 32'h0000_0001;
  localparam logic [31:0] EXP_UPL   = 32'h0000_0001;
`endif

  button_move_sequencer #(
    .REPEAT_DELAY (8),
    .REPEAT_PERIOD(4),
    .START_HOLD   (16)
  ) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Buttons   (btn),
    .o_Move      (move),
    .o_Game_Start(start),
    .o_Chord     (chord)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    btn = 4'd0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Runs n cycles, logging o_Move[b] per cycle, start pulses and chord
  // level; buttons switch to cv before cycle ca (ca<0: never).
  task automatic run_log(input int n, input int b, input int ca,
                         input logic [3:0] cv);
    pmask     = '0;
    smask     = '0;
    mv_or     = '0;
    chord_cnt = 0;
    start_cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (i == ca) btn = cv;
      step();
      if (move[b]) pmask[i] = 1'b1;
      if (start) begin
        smask[i] = 1'b1;
        start_cnt++;
      end
      if (chord) chord_cnt++;
      mv_or = mv_or | move;
    end
  endtask

  initial begin
    // Held through reset: no strobe until a fresh press.
    rst = 1'b1;
    btn = 4'b0001;
    repeat (3) step();
    chk("rst_move", 32'(move), 32'h0);
    chk("rst_start", 32'(start), 32'h0);
    chk("rst_chord", 32'(chord), 32'h0);
    rst = 1'b0;
    run_log(6, 0, -1, 4'd0);
    chk("s1_held_no_move", 32'(mv_or), 32'h0);
    btn = 4'b0000;
    step();
    chk("s1_release", 32'(move), 32'h0);
    btn = 4'b0001;
    step();
    chk("s1_press", 32'(move), 32'h1);
    step();
    chk("s1_once", 32'(move), 32'h0);
    idle(3);

    // Right held for 30 cycles.
    btn = 4'b1000;
    run_log(30, 3, -1, 4'd0);
    chk("s2_right_mask", pmask[31:0], EXP_RIGHT);
    chk("s2_right_only", 32'(mv_or), 32'h8);
    btn = 4'b0000;
    run_log(12, 3, -1, 4'd0);
    chk("s2_after_rel", 32'(mv_or), 32'h0);

    // Release on the cycle a repeat falls due suppresses it.
    btn = 4'b0010;
    run_log(12, 1, 8, 4'b0000);
    chk("s2b_rel_prio", pmask[31:0], 32'h1);
    chk("s2b_only_down", 32'(mv_or), 32'h2);
    idle(2);

    // Up+left together: up wins; left release ignored.
    btn = 4'b0101;
    run_log(14, 0, 10, 4'b0001);
    chk("s3_up_mask", pmask[31:0], EXP_UPL);
    chk("s3_only_up", 32'(mv_or), 32'h1);
    btn = 4'b0000;
    run_log(6, 0, -1, 4'd0);
    chk("s3_up_rel", 32'(mv_or), 32'h0);
    btn = 4'b0100;
    step();
    chk("s3_left_new", 32'(move), 32'h4);
    idle(3);

    // Chord held 40 cycles.
    btn = 4'b1111;
    run_log(40, 0, -1, 4'd0);
    chk("s4_chord_lvl", 32'(chord_cnt), 32'd40);
    chk("s4_no_move", 32'(mv_or), 32'h0);
    chk("s4_start_at", smask[31:0], 32'h0000_8000);
    chk("s4_start_cnt", 32'(start_cnt), 32'd1);
    btn = 4'b0010;
    step();
    chk("s4_rel_chord", 32'(chord), 32'h0);
    chk("s4_rel_move", 32'(move), 32'h0);
    run_log(4, 1, -1, 4'd0);
    chk("s4_held_down", 32'(mv_or), 32'h0);
    btn = 4'b0000;
    step();
    btn = 4'b0010;
    step();
    chk("s4_repress", 32'(move), 32'h2);
    idle(3);

    // Short chord: no start.
    btn = 4'b1111;
    run_log(10, 0, -1, 4'd0);
    chk("s5_chord_lvl", 32'(chord_cnt), 32'd10);
    chk("s5_no_start", 32'(start_cnt), 32'd0);
    btn = 4'b0000;
    run_log(20, 0, -1, 4'd0);
    chk("s5_idle_start", 32'(start_cnt), 32'd0);
    chk("s5_idle_chord", 32'(chord_cnt), 32'd0);
    chk("s5_idle_move", 32'(mv_or), 32'h0);

    // Reset on the edge a repeat is due.
    btn = 4'b0001;
    run_log(16, 0, -1, 4'd0);
    chk("s6_pre_mask", pmask[31:0], EXP_UPL);
    rst = 1'b1;
    step();
    chk("s6_rst_move", 32'(move), 32'h0);
    chk("s6_rst_start", 32'(start), 32'h0);
    chk("s6_rst_chord", 32'(chord), 32'h0);
    step();
    rst = 1'b0;
    run_log(12, 0, -1, 4'd0);
    chk("s6_idle_held", 32'(mv_or), 32'h0);
    btn = 4'b0000;
    step();
    btn = 4'b0001;
    step();
    chk("s6_fresh", 32'(move), 32'h1);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
